// File: rtl/cpu_mem_bus_if.sv
// CPU-side system bus interface for the NES core.
// Groups the CPU address/data pins, the PRG ROM port and the PPU register
// port. "master" is the system side (CPU core, ROM, PPU); "slave" is the
// bus/decoder block that answers it.
interface cpu_mem_bus_if #(
  parameter int PRG_AW = 15
);
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_we;
  logic [7:0]        cpu_rdata;
  logic              cpu_rdy;
  logic [PRG_AW-1:0] prg_addr;
  logic [7:0]        prg_rdata;
  logic              ppu_sel;
  logic [2:0]        ppu_reg;
  logic [7:0]        ppu_wdata;
  logic              ppu_we;
  logic [7:0]        ppu_rdata;
  logic              dma_busy;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, prg_rdata, ppu_rdata,
    input  cpu_rdata, cpu_rdy, prg_addr, ppu_sel, ppu_reg, ppu_wdata,
           ppu_we, dma_busy
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, prg_rdata, ppu_rdata,
    output cpu_rdata, cpu_rdy, prg_addr, ppu_sel, ppu_reg, ppu_wdata,
           ppu_we, dma_busy
  );
endinterface

// File: rtl/cpu_mem_bus.sv
// CPU-side system bus for the NES core.
// Decodes the 6502 address into 2 KB work RAM (mirrored x4), PPU registers
// (mirrored every 8 bytes) and the PRG ROM window, and hosts the $4014 OAM
// DMA engine that halts the CPU and streams one 256-byte page into PPU $2004.
// Optional feature: define CPU_OPEN_BUS_EN to add an open-bus latch so that
// unmapped reads return the last value seen on the bus instead of 8'hFF.
module cpu_mem_bus #(
  parameter int          RAM_AW  = 11,
  parameter int          PRG_AW  = 15,
  parameter logic [15:0] DMA_REG = 16'h4014
) (
  input logic          clk_ph1,
  input logic          rst,
  cpu_mem_bus_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] dma_byte;
  logic       cyc_par;
  logic       rdy;
  logic       busy;

  logic [7:0] ram [2**RAM_AW];

  logic [15:0] bus_addr;
  logic        ram_hit;
  logic        ppu_hit;
  logic        prg_hit;
  logic [7:0]  bus_rdata;
  logic [7:0]  open_val;
  logic        cpu_write;
  logic        dma_read;
  logic        dma_write;

  // Bus address comes from the CPU except while the DMA engine reads its page.
  always_comb begin
    dma_read  = (state == READ);
    dma_write = (state == WRITE);
    cpu_write = rdy && bus.cpu_we;
    bus_addr  = dma_read ? {page, idx} : bus.cpu_addr;
    ram_hit   = (bus_addr[15:13] == 3'b000);
    ppu_hit   = (bus_addr[15:13] == 3'b001);
    prg_hit   = bus_addr[15];
  end

  // Read-data mux; anything outside RAM/PPU/PRG reads the open-bus value.
  always_comb begin
    bus_rdata = open_val;
    if (ram_hit) begin
      bus_rdata = ram[bus_addr[RAM_AW-1:0]];
    end else if (ppu_hit) begin
      bus_rdata = bus.ppu_rdata;
    end else if (prg_hit) begin
      bus_rdata = bus.prg_rdata;
    end
  end

`ifdef CPU_OPEN_BUS_EN
  logic [7:0] bus_latch;

  // Open-bus latch tracks the last byte driven on the bus, write data included.
  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      bus_latch <= 8'hFF;
    end else if (dma_write) begin
      bus_latch <= dma_byte;
    end else if (cpu_write) begin
      bus_latch <= bus.cpu_wdata;
    end else begin
      bus_latch <= bus_rdata;
    end
  end

  assign open_val = bus_latch;
`else
  assign open_val = 8'hFF;
`endif

  // Work RAM write port; only the CPU writes, and only while it is not halted.
  always_ff @(posedge clk_ph1) begin
    if (cpu_write && ram_hit) begin
      ram[bus_addr[RAM_AW-1:0]] <= bus.cpu_wdata;
    end
  end

  // Free-running cycle parity, used to decide whether DMA needs an align cycle.
  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      cyc_par <= 1'b0;
    end else begin
      cyc_par <= ~cyc_par;
    end
  end

  // OAM DMA sequencer; rdy/busy are registered so they follow the state exactly.
  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      state    <= IDLE;
      page     <= 8'h00;
      idx      <= 8'h00;
      dma_byte <= 8'h00;
      rdy      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_write && (bus.cpu_addr == DMA_REG)) begin
            page  <= bus.cpu_wdata;
            idx   <= 8'h00;
            state <= HALT;
            rdy   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        HALT: begin
          state <= cyc_par ? ALIGN : READ;
        end
        ALIGN: begin
          state <= READ;
        end
        READ: begin
          dma_byte <= bus_rdata;
          state    <= WRITE;
        end
        WRITE: begin
          if (idx == 8'hFF) begin
            state <= IDLE;
            rdy   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // PPU port: DMA WRITE owns it outright, otherwise it follows a CPU access.
  always_comb begin
    bus.ppu_sel   = 1'b0;
    bus.ppu_we    = 1'b0;
    bus.ppu_reg   = bus_addr[2:0];
    bus.ppu_wdata = bus.cpu_wdata;
    if (!rst) begin
      if (dma_write) begin
        bus.ppu_sel   = 1'b1;
        bus.ppu_we    = 1'b1;
        bus.ppu_reg   = 3'd4;
        bus.ppu_wdata = dma_byte;
      end else if (dma_read && ppu_hit) begin
        bus.ppu_sel = 1'b1;
      end else if (rdy && ppu_hit) begin
        bus.ppu_sel = 1'b1;
        bus.ppu_we  = bus.cpu_we;
      end
    end
  end

  assign bus.prg_addr  = bus_addr[PRG_AW-1:0];
  assign bus.cpu_rdata = rdy ? bus_rdata : 8'hFF;
  assign bus.cpu_rdy   = rdy;
  assign bus.dma_busy  = busy;

endmodule

// File: tb/tb_cpu_mem_bus.sv
// Self-checking bench for cpu_mem_bus.
// Directed CPU accesses check the address map; OAM DMA transfers are checked
// against a queue of expected PPU $2004 writes filled before each trigger.
module tb_cpu_mem_bus;

  logic clk;
  logic rst;

  cpu_mem_bus_if #(.PRG_AW(15)) bus_if ();

  cpu_mem_bus dut (
    .clk_ph1 (clk),
    .rst     (rst),
    .bus     (bus_if)
  );

  int vectors;
  int miscompares;
  int pulses;
  logic mon_en;
  logic par_model;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model of the free-running cycle parity.
  always @(posedge clk) begin
    if (rst) par_model <= 1'b0;
    else     par_model <= ~par_model;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each DMA write to the PPU pops one expected byte.
  always @(negedge clk) begin
    if (mon_en && !rst && bus_if.ppu_we) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check_output("dma extra write", 32'd1, 32'd0);
      end else begin
        check_output("dma write", {bus_if.ppu_sel, bus_if.ppu_reg, bus_if.ppu_wdata},
                     {1'b1, 3'd4, exp_q.pop_front()});
      end
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus_if.cpu_addr  = a;
    bus_if.cpu_wdata = d;
    bus_if.cpu_we    = 1'b1;
    @(posedge clk); #1;
    bus_if.cpu_we    = 1'b0;
  endtask

  task automatic cpu_read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
    bus_if.cpu_addr = a;
    bus_if.cpu_we   = 1'b0;
    @(negedge clk);
    check_output(tag, bus_if.cpu_rdata, exp);
    @(posedge clk); #1;
  endtask

  // Trigger a DMA so the HALT cycle lands on the requested parity, then
  // measure how long the CPU is held off.
  task automatic run_dma(input string tag, input logic [7:0] pg, input logic halt_par,
                         input int exp_len);
    int low_cycles;
    if (par_model == halt_par) begin
      @(posedge clk); #1;
    end
    pulses = 0;
    mon_en = 1'b1;
    cpu_write(16'h4014, pg);
    bus_if.cpu_addr = 16'h0000;
    low_cycles = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (bus_if.cpu_rdy) break;
      low_cycles++;
      if (low_cycles == 1) begin
        check_output({tag, " rdata halted"}, bus_if.cpu_rdata, 8'hFF);
        check_output({tag, " busy"}, bus_if.dma_busy, 1'b1);
      end
      if (low_cycles == 10) begin
        bus_if.cpu_addr  = 16'h4014;
        bus_if.cpu_wdata = 8'h03;
        bus_if.cpu_we    = 1'b1;
      end
      if (low_cycles == 11) begin
        bus_if.cpu_addr = 16'h0000;
        bus_if.cpu_we   = 1'b0;
      end
    end
    check_output({tag, " halt length"}, low_cycles, exp_len);
    check_output({tag, " pulses"}, pulses, 256);
    check_output({tag, " queue left"}, exp_q.size(), 0);
    check_output({tag, " busy end"}, bus_if.dma_busy, 1'b0);
    mon_en = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic apply_stimulus();
    // Reset state
    @(negedge clk);
    check_output("reset rdy", bus_if.cpu_rdy, 1'b1);
    check_output("reset busy", bus_if.dma_busy, 1'b0);
    check_output("reset ppu", {bus_if.ppu_sel, bus_if.ppu_we}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // RAM and its mirrors
    cpu_write(16'h0003, 8'h11);
    cpu_write(16'h0002, 8'h5A);
    cpu_read_check("ram 0002", 16'h0002, 8'h5A);
    cpu_read_check("ram 0802", 16'h0802, 8'h5A);
    cpu_read_check("ram 1802", 16'h1802, 8'h5A);
    cpu_read_check("ram 0003", 16'h0003, 8'h11);

    // PRG window, and a PRG write must not land in RAM
    bus_if.prg_rdata = 8'h34;
    bus_if.cpu_addr  = 16'hFFFC;
    @(negedge clk);
    check_output("prg addr", bus_if.prg_addr, 15'h7FFC);
    check_output("prg rdata", bus_if.cpu_rdata, 8'h34);
    @(posedge clk); #1;
    cpu_write(16'h0000, 8'h22);
    cpu_write(16'h8000, 8'h77);
    cpu_read_check("prg write ignored", 16'h0000, 8'h22);

    // PPU register write and mirrored read
    bus_if.cpu_addr  = 16'h2006;
    bus_if.cpu_wdata = 8'h3F;
    bus_if.cpu_we    = 1'b1;
    @(negedge clk);
    check_output("ppu write", {bus_if.ppu_sel, bus_if.ppu_we, bus_if.ppu_reg, bus_if.ppu_wdata},
                 {1'b1, 1'b1, 3'd6, 8'h3F});
    @(posedge clk); #1;
    bus_if.cpu_we    = 1'b0;
    bus_if.ppu_rdata = 8'h9C;
    bus_if.cpu_addr  = 16'h3FFE;
    @(negedge clk);
    check_output("ppu read", {bus_if.ppu_sel, bus_if.ppu_we, bus_if.ppu_reg}, {1'b1, 1'b0, 3'd6});
    check_output("ppu rdata", bus_if.cpu_rdata, 8'h9C);
    @(posedge clk); #1;

    // Unmapped space
`ifdef CPU_OPEN_BUS_EN
    bus_if.prg_rdata = 8'hA5;
    cpu_read_check("prg A5", 16'h8000, 8'hA5);
    cpu_read_check("open bus 5000", 16'h5000, 8'hA5);
`else
    cpu_read_check("unmapped 5000", 16'h5000, 8'hFF);
    cpu_read_check("unmapped 4014", 16'h4014, 8'hFF);
`endif

    // Fill page $02 with an ascending pattern
    for (int i = 0; i < 256; i++) cpu_write(16'h0200 + 16'(i), 8'(i));

    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    run_dma("dma even", 8'h02, 1'b0, 513);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    run_dma("dma odd", 8'h02, 1'b1, 514);

    bus_if.ppu_rdata = 8'h5C;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'h5C);
    run_dma("dma ppu page", 8'h21, 1'b1, 514);

    // Reset part-way through a transfer
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    pulses = 0;
    mon_en = 1'b1;
    cpu_write(16'h4014, 8'h02);
    bus_if.cpu_addr = 16'h0000;
    for (int t = 0; t < 1000 && pulses < 100; t++) @(negedge clk);
    check_output("dma reached byte 100", pulses, 100);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_output("abort state", {bus_if.cpu_rdy, bus_if.dma_busy, bus_if.ppu_we}, 3'b100);
    begin
      int stray;
      stray = 0;
      for (int t = 0; t < 8; t++) begin
        @(negedge clk);
        if (bus_if.ppu_we || !bus_if.cpu_rdy) stray++;
      end
      check_output("abort stays idle", stray, 0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    run_dma("dma restart", 8'h02, 1'b0, 513);
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    pulses           = 0;
    mon_en           = 1'b0;
    rst              = 1'b1;
    bus_if.cpu_addr  = 16'h0000;
    bus_if.cpu_wdata = 8'h00;
    bus_if.cpu_we    = 1'b0;
    bus_if.prg_rdata = 8'h00;
    bus_if.ppu_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/cpu_mem_bus.md
Name: cpu_mem_bus

Overview:
- CPU-side system bus for the NES core. Sits directly between the 6502 core's address/data pins and memory/peripherals.
- Decodes the CPU address and returns the read byte on the CPU data input. Holds 2 KB internal work RAM and forwards cycles to PRG ROM and PPU registers.
- Contains the OAM DMA engine ($4014), which halts the CPU and copies one 256-byte page into PPU register $2004.

Parameters:
RAM_AW, 11, work RAM address width (2^RAM_AW bytes)
PRG_AW, 15, PRG ROM window address width
DMA_REG, 16'h4014, address whose write triggers OAM DMA

Ports:
clk_ph1  in  1  single system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
cpu_addr  in  16  CPU address bus
cpu_wdata  in  8  CPU write data
cpu_we  in  1  CPU write strobe (1 = write cycle)
cpu_rdata  out  8  read data to CPU data bus (combinational)
cpu_rdy  out  1  1 = CPU may advance; 0 = CPU halted by DMA
prg_addr  out  PRG_AW  PRG ROM address
prg_rdata  in  8  PRG ROM data (combinational)
ppu_sel  out  1  PPU register access this cycle
ppu_reg  out  3  PPU register index
ppu_wdata  out  8  PPU write data
ppu_we  out  1  PPU register write strobe
ppu_rdata  in  8  PPU register read data
dma_busy  out  1  DMA in progress

Behaviour:
- Reset values: cpu_rdy=1, dma_busy=0, ppu_we=0, ppu_sel=0, state IDLE, idx=0, page=0, cyc_par=0, bus latch=8'hFF. RAM contents are not cleared.
- cyc_par: free-running 1-bit toggle, every clock.
- Address map (bus address = cpu_addr in IDLE, {page,idx} during DMA READ):
  - $0000-$1FFF: RAM[addr[10:0]], mirrored ×4.
  - $2000-$3FFF: PPU, ppu_reg=addr[2:0], mirrored every 8.
  - $8000-$FFFF: PRG, prg_addr=addr[14:0].
  - All else: unmapped, reads 8'hFF.
- Reads are combinational, same cycle as address. RAM writes occur at the clock edge when cpu_we=1, cpu_rdy=1 and address is in RAM range.
- PRG writes are ignored.
- ppu_sel/ppu_we/ppu_wdata are combinational:
  - CPU access in PPU range with cpu_rdy=1: ppu_we=cpu_we.
  - DMA WRITE: ppu_sel=1, ppu_we=1, ppu_reg=4, ppu_wdata=dma_byte.
- DMA FSM states: IDLE, HALT, ALIGN, READ, WRITE.
  - IDLE: on edge with cpu_we=1, cpu_addr==DMA_REG and cpu_rdy=1, latch page=cpu_wdata, idx=0, go HALT.
  - HALT (1 cycle): if cyc_par==1 go ALIGN, else go READ.
  - ALIGN (1 cycle): go READ.
  - READ: bus address {page,idx}; latch dma_byte at edge; go WRITE.
  - WRITE: issue PPU write. If idx==8'hFF go IDLE, else idx+1 and go READ.
- cpu_rdy=0 and dma_busy=1 in every state except IDLE. Total halt is 513 cycles (even) or 514 cycles (odd).
- During DMA: cpu_addr and cpu_we are ignored; cpu_rdata=8'hFF. Writes to $4014 cannot retrigger.
- DMA source page rules:
  - Page $20-$3F reads ppu_rdata with ppu_sel=1, ppu_we=0.
  - Unmapped pages yield 8'hFF.
- Reset mid-DMA: next cycle state=IDLE, cpu_rdy=1, no further ppu_we. The DMA is abandoned, not resumed.

Optional Feature:
- Macro: CPU_OPEN_BUS_EN.
- Defined: an 8-bit bus latch captures, every clock, the final bus value (the read data, or the write data on write cycles). Unmapped reads return the latch instead of 8'hFF. The latch resets to 8'hFF.
- Undefined: unmapped reads return 8'hFF; no latch is instantiated.

Test Plan:
- RAM mirror: write 8'h5A to $0002 -> reads of $0002/$0802/$1802 all return 8'h5A; $0003 unaffected.
- PRG: cpu_addr=$FFFC, prg_rdata=8'h34 -> prg_addr=15'h7FFC, cpu_rdata=8'h34; write to $8000 leaves RAM unchanged.
- PPU: write 8'h3F to $2006 -> ppu_sel=1, ppu_we=1, ppu_reg=6, ppu_wdata=8'h3F; read $3FFE -> ppu_reg=6, ppu_we=0.
- DMA: RAM $0200+i=i, write 8'h02 to $4014 with cyc_par=0 at HALT -> cpu_rdy low 513 cycles, 256 ppu_we pulses on reg 4 with data 00..FF in order. With cyc_par=1 -> 514 cycles.
- Reset at DMA byte 100 -> following cycle cpu_rdy=1, dma_busy=0, ppu_we=0. New DMA restarts at idx=0.
- Unmapped $5000 -> 8'hFF. With CPU_OPEN_BUS_EN: read $8000 (=8'hA5), then $5000 -> 8'hA5.
